// File: rtl/sprite_anim_renderer.sv
// Sprite pixel engine: maps DrawX/DrawY into an animated, optionally mirrored sprite ROM
// and returns a transparency-masked palette index aligned to the ROM read latency.
module sprite_anim_renderer #(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int FRAMES          = 4,
    parameter int IDX_W           = 3,
    parameter int ROM_LAT         = 1,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FRAME_TICKS     = 8,
    localparam int ADDR_W         = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int FR_W           = $clog2(FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic              anim_restart,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic              pix_valid,
    output logic [IDX_W-1:0]  pix_idx,
    output logic [FR_W-1:0]   anim_frame
);

    localparam int XW   = $clog2(SPR_W);
    localparam int YW   = $clog2(SPR_H);
    localparam int TK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [10:0]      SPR_W_L   = 11'(SPR_W);
    localparam logic [10:0]      SPR_H_L   = 11'(SPR_H);
    localparam logic [IDX_W-1:0] TRANSP    = IDX_W'(TRANSPARENT_IDX);
    localparam logic [TK_W-1:0]  TICK_LAST = TK_W'(FRAME_TICKS - 1);

    // Pixels matching the transparent index are reported as "no sprite here".
    function automatic logic [IDX_W-1:0] mask_idx(input logic hit, input logic [IDX_W-1:0] q);
        return (hit && (q != TRANSP)) ? q : '0;
    endfunction

    logic signed [10:0] lx_p0;
    logic signed [10:0] ly_p0;
    logic               in_box_p0;
    logic [XW-1:0]      col_p0;
    logic               vld_p0;
    logic [ROM_LAT-1:0] vld_p1;
    logic               hit_p1;
    logic [TK_W-1:0]    tick_q;

    // Stage 0: 11-bit signed offsets; a negative offset or one past the extent is outside,
    // so sprites hanging off the right/bottom edge clip instead of wrapping.
    assign lx_p0     = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x});
    assign ly_p0     = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y});
    assign in_box_p0 = !lx_p0[10] && ($unsigned(lx_p0) < SPR_W_L) &&
                       !ly_p0[10] && ($unsigned(ly_p0) < SPR_H_L);
    assign col_p0    = flip_h ? ~lx_p0[XW-1:0] : lx_p0[XW-1:0];
    assign rom_address = in_box_p0 ? {anim_frame, ly_p0[YW-1:0], col_p0} : '0;
    assign vld_p0    = in_box_p0 && blank;

    // Stage 1: hit flag rides alongside the ROM read for ROM_LAT cycles.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= '0;
        end else begin
            vld_p1[0] <= vld_p0;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_p1[i] <= vld_p1[i-1];
            end
        end
    end

    assign hit_p1 = vld_p1[ROM_LAT-1];

    // Stage 2: registered, transparency-masked output.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            pix_idx   <= '0;
        end else begin
            pix_valid <= hit_p1 && (rom_q != TRANSP);
            pix_idx   <= mask_idx(hit_p1, rom_q);
        end
    end

    // Animation step: restart wins over a coincident tick and does not depend on anim_en.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q     <= '0;
            anim_frame <= '0;
        end else if (anim_restart) begin
            tick_q     <= '0;
            anim_frame <= '0;
        end else if (anim_en && frame_tick) begin
            if (tick_q == TICK_LAST) begin
                tick_q     <= '0;
                anim_frame <= anim_frame + 1'b1;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: ROM word = addr[2:0], directed pixels with
// hand-computed results checked through a latency-aware scoreboard.
module tb_sprite_anim_renderer;

    logic        vga_clk;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, flip_h, anim_en, anim_restart, frame_tick;
    logic [11:0] rom_address;
    logic [2:0]  rom_q;
    logic        pix_valid;
    logic [2:0]  pix_idx;
    logic [1:0]  anim_frame;

    sprite_anim_renderer dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
        .anim_en(anim_en), .anim_restart(anim_restart), .frame_tick(frame_tick),
        .rom_address(rom_address), .rom_q(rom_q), .pix_valid(pix_valid),
        .pix_idx(pix_idx), .anim_frame(anim_frame)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // One-cycle synchronous ROM whose word is the low three address bits.
    always @(posedge vga_clk) rom_q <= rom_address[2:0];

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int         due;
        logic       v;
        logic [2:0] idx;
        string      name;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge vga_clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
                fails++;
                $display("FAIL %s: output slot missed (due %0d, now %0d)", e.name, e.due, cyc);
            end else if (pix_valid !== e.v || pix_idx !== e.idx) begin
                fails++;
                $display("FAIL %s: pix_valid=%0b pix_idx=%0d, expected %0b/%0d",
                         e.name, pix_valid, pix_idx, e.v, e.idx);
            end
        end
    end

    task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic fl,
                         input logic [9:0] x, input logic [9:0] y, input logic b,
                         input logic [11:0] ea, input logic ev, input logic [2:0] ei,
                         input string nm);
        @(negedge vga_clk);
        pos_x = px; pos_y = py; flip_h = fl;
        DrawX = x;  DrawY = y;  blank = b;
        #1;
        chk({nm, "_addr"}, int'(rom_address), int'(ea));
        sb.push_back('{due: cyc + 2, v: ev, idx: ei, name: nm});
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge vga_clk) frame_tick = 1'b1;
            @(negedge vga_clk) frame_tick = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(negedge vga_clk);
            k++;
        end
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d outputs never checked", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; DrawX = 0; DrawY = 0; blank = 0; pos_x = 0; pos_y = 0;
        flip_h = 0; anim_en = 0; anim_restart = 0; frame_tick = 0;
        repeat (3) @(negedge vga_clk);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_idx",   int'(pix_idx), 0);
        chk("rst_frame", int'(anim_frame), 0);
        reset_n = 1'b1;

        // Placement, edges, transparency and blank, frame 0 at (100,50)
        drive(100, 50, 0, 100, 50, 1, 12'd0,   0, 3'd0, "origin_transp");
        drive(100, 50, 0, 105, 50, 1, 12'd5,   1, 3'd5, "opaque5");
        drive(100, 50, 0, 105, 50, 0, 12'd5,   0, 3'd0, "blank_off");
        drive(100, 50, 0, 131, 50, 1, 12'd31,  1, 3'd7, "right_edge");
        drive(100, 50, 0, 132, 50, 1, 12'd0,   0, 3'd0, "past_right");
        drive(100, 50, 0, 99,  50, 1, 12'd0,   0, 3'd0, "before_left");
        drive(100, 50, 0, 101, 81, 1, 12'd993, 1, 3'd1, "bottom_row");
        drive(100, 50, 0, 101, 82, 1, 12'd0,   0, 3'd0, "past_bottom");
        drive(100, 50, 0, 105, 49, 1, 12'd0,   0, 3'd0, "above_top");
        // Mirrored
        drive(100, 50, 1, 100, 51, 1, 12'd63,  1, 3'd7, "flip_left");
        drive(100, 50, 1, 131, 51, 1, 12'd32,  0, 3'd0, "flip_right");
        drive(100, 50, 1, 110, 60, 1, 12'd341, 1, 3'd5, "flip_mid");
        // Right-edge clipping, no wrap past 1023
        drive(1000, 0, 0, 1023, 0, 1, 12'd23,  1, 3'd7, "clip_1023");
        drive(1000, 0, 0, 0,    0, 1, 12'd0,   0, 3'd0, "clip_wrap0");
        drive(1000, 0, 0, 1010, 1, 1, 12'd42,  1, 3'd2, "clip_mid");
        drive(1000, 0, 0, 999,  1, 1, 12'd0,   0, 3'd0, "clip_left");
        drain();

        // Animation
        anim_en = 1'b1;
        pulse(7);  chk("frame_after7",  int'(anim_frame), 0);
        pulse(1);  chk("frame_after8",  int'(anim_frame), 1);
        pulse(8);  chk("frame_after16", int'(anim_frame), 2);
        drive(0, 0, 0, 0, 0, 1, 12'd2048, 0, 3'd0, "frame2_origin");
        drive(0, 0, 0, 3, 0, 1, 12'd2051, 1, 3'd3, "frame2_px3");
        drive(0, 0, 1, 0, 0, 1, 12'd2079, 1, 3'd7, "frame2_flip");
        drain();
        pulse(16); chk("frame_wrap32",  int'(anim_frame), 0);
        pulse(8);  chk("frame_after40", int'(anim_frame), 1);
        anim_en = 1'b0;
        pulse(20); chk("frame_hold",    int'(anim_frame), 1);
        anim_en = 1'b1;
        pulse(7);  chk("frame_tick7",   int'(anim_frame), 1);
        @(negedge vga_clk) begin frame_tick = 1'b1; anim_restart = 1'b1; end
        @(negedge vga_clk) begin frame_tick = 1'b0; anim_restart = 1'b0; end
        chk("restart_frame", int'(anim_frame), 0);
        pulse(7);  chk("restart_tick0", int'(anim_frame), 0);
        pulse(1);  chk("restart_step",  int'(anim_frame), 1);

        // Reset mid-line with the sprite visible in frame 1
        repeat (3) drive(100, 50, 0, 105, 50, 1, 12'd1029, 1, 3'd5, "pre_reset");
        @(negedge vga_clk);
        @(negedge vga_clk);
        chk("pre_reset_valid", int'(pix_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", int'(pix_valid), 0);
        chk("async_idx",   int'(pix_idx), 0);
        chk("async_frame", int'(anim_frame), 0);
        chk("async_addr",  int'(rom_address), 5);
        DrawX = 0;
        @(negedge vga_clk);
        @(negedge vga_clk) reset_n = 1'b1;
        sb.push_back('{due: cyc + 1, v: 1'b0, idx: 3'd0, name: "post_rst_1"});
        sb.push_back('{due: cyc + 2, v: 1'b0, idx: 3'd0, name: "post_rst_2"});
        drive(100, 50, 0, 105, 50, 1, 12'd5, 1, 3'd5, "post_rst_first");
        drive(100, 50, 0, 106, 50, 1, 12'd6, 1, 3'd6, "post_rst_next");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
- Parametrised sprite pixel engine for the VGA path: maps the current DrawX/DrawY to an address in an external synchronous sprite ROM holding FRAMES animation frames of SPR_W x SPR_H palette indices.
- Places the sprite at a runtime position and supports horizontal mirroring.
- Advances the animation frame on a vsync-rate tick.
- Emits a transparency-aware palette index, pipeline-aligned to the ROM latency, for the downstream palette/compositor.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two)
- SPR_H, 32, sprite height in pixels (power of two)
- FRAMES, 4, animation frames stored consecutively in ROM (power of two)
- IDX_W, 3, palette index width (ROM data width)
- ROM_LAT, 1, ROM read latency in cycles (>=1)
- TRANSPARENT_IDX, 0, palette index treated as transparent
- FRAME_TICKS, 8, frame_tick pulses per animation step (>=1)
- ADDR_W, clog2(FRAMES*SPR_W*SPR_H), ROM address width (derived, localparam)

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- pos_x  in  10  sprite left edge
- pos_y  in  10  sprite top edge
- flip_h  in  1  1 = mirror horizontally
- anim_en  in  1  1 = animation advances
- anim_restart  in  1  sync clear of frame and tick counter
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- rom_address  out  ADDR_W  to sprite ROM
- rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after its address
- pix_valid  out  1  1 = opaque sprite pixel in active video
- pix_idx  out  IDX_W  palette index; 0 when pix_valid=0
- anim_frame  out  clog2(FRAMES)  current animation frame

Behaviour:
- Reset (reset_n=0, async): pix_valid=0, pix_idx=0, anim_frame=0, tick counter=0, all pipeline delay stages cleared.
- rom_address is combinational from the current inputs.
- lx = DrawX-pos_x and ly = DrawY-pos_y, computed at 11 bits.
- in_box = (DrawX>=pos_x) && (DrawX-pos_x<SPR_W) && (DrawY>=pos_y) && (DrawY-pos_y<SPR_H). No wrap: a sprite partially off the right or bottom edge clips; pos_x+SPR_W>1023 must not alias.
- col = flip_h ? SPR_W-1-lx : lx.
- rom_address = anim_frame*SPR_W*SPR_H + ly*SPR_W + col when in_box; otherwise rom_address = 0.
- Delay line: (in_box && blank) delayed ROM_LAT cycles, so it aligns with rom_q.
- Output register, one cycle after alignment:
  - pix_valid <= aligned_hit && (rom_q != TRANSPARENT_IDX)
  - pix_idx <= pix_valid-condition ? rom_q : 0
- Total latency from DrawX/DrawY to pix_valid/pix_idx = ROM_LAT+1 cycles. This is fixed, including across flip and frame changes.
- Animation:
  - When anim_en=1 and frame_tick=1: if tick==FRAME_TICKS-1, tick<=0 and anim_frame<=anim_frame+1 mod FRAMES (wraps FRAMES-1 -> 0); else tick<=tick+1.
  - When anim_en=0: tick and anim_frame hold; frame_tick is ignored.
  - anim_restart=1 clears tick and anim_frame the same edge and has priority over a simultaneous frame_tick.
- A changed anim_frame affects rom_address the cycle after the update. frame_tick is issued in blanking, so there is no mid-line tearing.
- pos_x, pos_y and flip_h are used live. The caller changes them only during blanking.
- Reset asserted mid-line clears all outputs immediately. Pixels in flight are discarded; there is no resume.

Test Plan:
- Reset: reset_n=0 mid-line with sprite visible -> pix_valid=0, pix_idx=0, anim_frame=0 asynchronously. After release, first valid output appears ROM_LAT+1 cycles after the first in-box pixel.
- Placement and latency: pos=(100,50), ROM model with word = addr[2:0], DrawX=100, DrawY=50, blank=1 -> rom_address=0.
  - DrawX=131 -> rom_address=31.
  - DrawX=132 -> rom_address=0, and pix_valid=0 two cycles later.
  - Output index matches the ROM 2 cycles after each DrawX when ROM_LAT=1.
- Flip: pos=(100,50), flip_h=1, DrawX=100, DrawY=51 -> rom_address=63. DrawX=131 -> rom_address=32.
- Transparency and blank:
  - In-box pixel with rom_q=0 -> pix_valid=0, pix_idx=0.
  - rom_q=5 with blank=0 -> pix_valid=0.
  - rom_q=5 with blank=1 -> pix_valid=1, pix_idx=5.
- Animation: anim_en=1, FRAME_TICKS=8, 8 frame_tick pulses -> anim_frame=1.
  - After 32 pulses -> anim_frame=0 (wrap).
  - In frame 2, pos=(0,0), Draw=(0,0) -> rom_address=2048.
- Hold and restart:
  - anim_en=0 with 20 pulses -> anim_frame unchanged.
  - anim_restart and frame_tick in the same cycle at tick=7 -> anim_frame=0, tick=0.
- Clipping: pos_x=1000, DrawX=1023 -> in_box, rom_address col=23. DrawX=0 -> not in box, no wrap.
